// File: rtl/millis_timer_irq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : millis_timer_irq_pkg
//  Brief    : Shared register map, CTRL bit positions and alarm state encoding
//             for the millisecond alarm timer.
//  Revision : 1.0 - initial release
// ============================================================================
package millis_timer_irq_pkg;

  // Word addresses on the register port
  localparam logic [1:0] MT_CTRL   = 2'd0;
  localparam logic [1:0] MT_CMP    = 2'd1;
  localparam logic [1:0] MT_PERIOD = 2'd2;
  localparam logic [1:0] MT_SNAP   = 2'd3;

  // CTRL bit positions
  localparam int CTRL_EN       = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_PEND     = 2;
  localparam int CTRL_OVR      = 3;

  // Alarm state
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FIRED = 2'd2
  } mt_state_e;

endpackage
`default_nettype wire

// File: rtl/millis_cmp_wrap.sv
`default_nettype none
// ============================================================================
//  Module   : millis_cmp_wrap
//  Brief    : Combinational wrap-safe "time a has reached time b" test.
//             True when (a - b) mod 2^32 lies in the non-negative half.
//  Revision : 1.0 - initial release
// ============================================================================
module millis_cmp_wrap
  import millis_timer_irq_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_reached
);

  logic [31:0] w_diff;

  assign w_diff    = i_a - i_b;
  // Sign bit clear means a is at or after b within half the counter range
  assign o_reached = (w_diff <= 32'h7FFF_FFFF);

endmodule
`default_nettype wire

// File: rtl/millis_timer_irq.sv
`default_nettype none
// ============================================================================
//  Module   : millis_timer_irq
//  Brief    : Programmable millisecond alarm. Compares the free-running
//             millis count against CMP and raises a level interrupt; optional
//             periodic re-arm. Build option: MILLIS_TIMER_PERIODIC_EN enables
//             the PERIODIC bit, PERIOD register, re-arm adder and OVR flag.
//  Revision : 1.0 - initial release
// ============================================================================
module millis_timer_irq
  import millis_timer_irq_pkg::*;
#(
  parameter logic [31:0] PERIOD_RST = 32'd1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] millis,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq,
  input  logic        irq_ack
);

  mt_state_e   r_state;
  logic        r_en;
  logic        r_pend;
  logic [31:0] r_cmp;
  logic [31:0] r_snap;
  logic [31:0] r_rdata;

  logic        w_ctrl_wr;
  logic        w_cmp_wr;
  logic        w_disable;
  logic        w_clear;
  logic        w_hit;
  logic [31:0] w_ctrl_rd;
  logic [31:0] w_period_rd;
  logic [31:0] w_rdata;

  assign w_ctrl_wr = we && (addr == MT_CTRL);
  assign w_cmp_wr  = we && (addr == MT_CMP);
  assign w_disable = w_ctrl_wr && !wdata[CTRL_EN];
  // Acknowledge by either source only matters while an alarm is pending
  assign w_clear   = (r_state == FIRED) &&
                     (irq_ack || (w_ctrl_wr && wdata[CTRL_PEND]));

  millis_cmp_wrap u_hit_cmp (
    .i_a       (millis),
    .i_b       (r_cmp),
    .o_reached (w_hit)
  );

`ifdef MILLIS_TIMER_PERIODIC_EN
  logic        r_periodic;
  logic        r_ovr;
  logic [31:0] r_period;
  logic        w_periodic;
  logic        w_period_wr;
  logic [31:0] w_next_cmp;
  logic        w_overrun;

  assign w_period_wr = we && (addr == MT_PERIOD);
  // A CTRL write that clears the alarm also decides whether it re-arms
  assign w_periodic  = w_ctrl_wr ? wdata[CTRL_PERIODIC] : r_periodic;
  assign w_next_cmp  = r_cmp + r_period;

  millis_cmp_wrap u_ovr_cmp (
    .i_a       (millis),
    .i_b       (w_next_cmp),
    .o_reached (w_overrun)
  );

  assign w_ctrl_rd   = {28'd0, r_ovr, r_pend, r_periodic, r_en};
  assign w_period_rd = r_period;
`else
  logic w_unused_period_rst;

  assign w_unused_period_rst = ^PERIOD_RST;
  assign w_ctrl_rd   = {29'd0, r_pend, 1'b0, r_en};
  assign w_period_rd = 32'd0;
`endif

  // Read mux, captured into rdata on the next edge
  always_comb begin
    w_rdata = 32'd0;
    case (addr)
      MT_CTRL:   w_rdata = w_ctrl_rd;
      MT_CMP:    w_rdata = r_cmp;
      MT_PERIOD: w_rdata = w_period_rd;
      MT_SNAP:   w_rdata = r_snap;
      default:   w_rdata = 32'd0;
    endcase
  end

  // Register file and alarm FSM; later branches only apply when no higher
  // priority event (disable, clear, hit) claimed this edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_en       <= 1'b0;
      r_pend     <= 1'b0;
      r_cmp      <= 32'd0;
      r_snap     <= 32'd0;
      r_rdata    <= 32'd0;
`ifdef MILLIS_TIMER_PERIODIC_EN
      r_periodic <= 1'b0;
      r_ovr      <= 1'b0;
      r_period   <= PERIOD_RST;
`endif
    end else begin
      r_rdata <= w_rdata;

      if (w_cmp_wr) r_cmp <= wdata;
      if (w_ctrl_wr) r_en <= wdata[CTRL_EN];
`ifdef MILLIS_TIMER_PERIODIC_EN
      if (w_period_wr) r_period <= wdata;
      if (w_ctrl_wr) begin
        r_periodic <= wdata[CTRL_PERIODIC];
        if (wdata[CTRL_OVR]) r_ovr <= 1'b0;
      end
`endif

      if (w_disable) begin
        r_state <= IDLE;
        r_pend  <= 1'b0;
      end else if (w_clear) begin
        r_pend <= 1'b0;
`ifdef MILLIS_TIMER_PERIODIC_EN
        if (w_periodic) begin
          r_cmp   <= w_next_cmp;
          r_state <= ARMED;
          if (w_overrun) r_ovr <= 1'b1;
        end else begin
          r_en    <= 1'b0;
          r_state <= IDLE;
        end
`else
        r_en    <= 1'b0;
        r_state <= IDLE;
`endif
      end else if ((r_state == ARMED) && w_hit) begin
        r_state <= FIRED;
        r_pend  <= 1'b1;
        r_snap  <= millis;
      end else if ((r_state == IDLE) && w_ctrl_wr && wdata[CTRL_EN]) begin
        r_state <= ARMED;
      end
    end
  end

  assign rdata = r_rdata;
  assign irq   = r_pend;

endmodule
`default_nettype wire

// File: tb/tb_millis_timer_irq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_millis_timer_irq
//  Brief    : Directed self-checking bench for millis_timer_irq.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_millis_timer_irq;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_CMP    = 2'd1;
  localparam logic [1:0] A_PERIOD = 2'd2;
  localparam logic [1:0] A_SNAP   = 2'd3;

`ifdef MILLIS_TIMER_PERIODIC_EN
  localparam logic [31:0] PERIOD_EXP = 32'd1000;
`else
  localparam logic [31:0] PERIOD_EXP = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] millis;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;
  logic        irq_ack;

  int n_tests = 0;
  int n_fail  = 0;

  always #10 clk = ~clk;

  millis_timer_irq dut (
    .clk     (clk),
    .reset   (reset),
    .millis  (millis),
    .we      (we),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .irq     (irq),
    .irq_ack (irq_ack)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    addr = a;
    tick();
    d = rdata;
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1; we = 1'b0; addr = A_CTRL; wdata = 32'd0;
    millis = 32'd0; irq_ack = 1'b0;
    repeat (2) tick();
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
    n_tests++;
    if (rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    #5 reset = 1'b0;
    rd(A_CTRL, v);
    n_tests++;
    if (v !== 32'd0) begin n_fail++; $display("FAIL reset_ctrl: got %h want 0", v); end
    rd(A_CMP, v);
    n_tests++;
    if (v !== 32'd0) begin n_fail++; $display("FAIL reset_cmp: got %h want 0", v); end
    rd(A_PERIOD, v);
    n_tests++;
    if (v !== PERIOD_EXP) begin n_fail++; $display("FAIL reset_period: got %h want %h", v, PERIOD_EXP); end
    rd(A_SNAP, v);
    n_tests++;
    if (v !== 32'd0) begin n_fail++; $display("FAIL reset_snap: got %h want 0", v); end
  endtask

  task automatic test_oneshot();
    logic [31:0] v;
    logic        early;
    millis = 32'd100;
    wr(A_CMP, 32'd105);
    wr(A_CTRL, 32'h1);
    early = 1'b0;
    for (int m = 100; m <= 104; m++) begin
      millis = m;
      tick();
      if (irq !== 1'b0) early = 1'b1;
    end
    n_tests++;
    if (early) begin n_fail++; $display("FAIL oneshot_early: irq seen before 105, want 0"); end
    millis = 32'd105;
    tick();
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL oneshot_fire: irq=%b want 1", irq); end
    rd(A_SNAP, v);
    n_tests++;
    if (v !== 32'd105) begin n_fail++; $display("FAIL oneshot_snap: got %0d want 105", v); end
    rd(A_CTRL, v);
    n_tests++;
    if (v !== 32'h5) begin n_fail++; $display("FAIL oneshot_ctrl_pend: got %h want 5", v); end
    ack();
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL oneshot_ack: irq=%b want 0", irq); end
    rd(A_CTRL, v);
    n_tests++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL oneshot_ctrl_idle: got %h want 0", v); end
  endtask

  task automatic test_past_and_w1c();
    logic [31:0] v;
    millis = 32'd200;
    wr(A_CMP, 32'd150);
    wr(A_CTRL, 32'h1);
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL past_arm_edge: irq=%b want 0", irq); end
    tick();
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL past_fire: irq=%b want 1", irq); end
    wr(A_CTRL, 32'h5);
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL w1c_clear: irq=%b want 0", irq); end
    n_tests++;
    if (rdata !== 32'h5) begin n_fail++; $display("FAIL w1c_read_old: got %h want 5", rdata); end
    rd(A_CTRL, v);
    n_tests++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL w1c_ctrl: got %h want 0", v); end
  endtask

  task automatic test_wrap();
    logic [31:0] seq [4];
    logic        early;
    seq = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
    millis = 32'hFFFF_FFFE;
    wr(A_CMP, 32'h2);
    wr(A_CTRL, 32'h1);
    early = 1'b0;
    for (int i = 0; i < 4; i++) begin
      millis = seq[i];
      tick();
      if (irq !== 1'b0) early = 1'b1;
    end
    n_tests++;
    if (early) begin n_fail++; $display("FAIL wrap_early: irq seen before millis=2, want 0"); end
    millis = 32'h2;
    tick();
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL wrap_fire: irq=%b want 1", irq); end
    ack();
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL wrap_ack: irq=%b want 0", irq); end
  endtask

  task automatic test_priority();
    logic [31:0] v;
    millis = 32'd40;
    wr(A_CMP, 32'd50);
    wr(A_CTRL, 32'h1);
    millis = 32'd50;
    wr(A_CTRL, 32'h0);
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL prio_disable_hit: irq=%b want 0", irq); end
    tick();
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL prio_stays_idle: irq=%b want 0", irq); end
    millis = 32'd55;
    wr(A_CMP, 32'd60);
    n_tests++;
    if (rdata !== 32'd50) begin n_fail++; $display("FAIL read_during_write: got %0d want 50", rdata); end
    wr(A_CTRL, 32'h1);
    ack();
    rd(A_CTRL, v);
    n_tests++;
    if (v !== 32'h1) begin n_fail++; $display("FAIL ack_armed_ctrl: got %h want 1", v); end
    millis = 32'd60;
    tick();
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL ack_armed_fire: irq=%b want 1", irq); end
    ack();
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL ack_armed_clear: irq=%b want 0", irq); end
  endtask

`ifdef MILLIS_TIMER_PERIODIC_EN
  task automatic test_periodic();
    logic [31:0] v;
    logic [31:0] t;
    millis = 32'd0;
    wr(A_CMP, 32'd10);
    wr(A_PERIOD, 32'd5);
    wr(A_CTRL, 32'h3);
    for (int k = 0; k < 3; k++) begin
      t = 32'd10 + 32'd5 * k;
      millis = t - 32'd1;
      tick();
      n_tests++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL periodic_early_%0d: irq=%b want 0", t, irq); end
      millis = t;
      tick();
      n_tests++;
      if (irq !== 1'b1) begin n_fail++; $display("FAIL periodic_fire_%0d: irq=%b want 1", t, irq); end
      ack();
      n_tests++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL periodic_ack_%0d: irq=%b want 0", t, irq); end
    end
    rd(A_CMP, v);
    n_tests++;
    if (v !== 32'd25) begin n_fail++; $display("FAIL periodic_cmp: got %0d want 25", v); end
    rd(A_CTRL, v);
    n_tests++;
    if (v !== 32'h3) begin n_fail++; $display("FAIL periodic_ctrl: got %h want 3", v); end
    wr(A_CTRL, 32'h0);
  endtask

  task automatic test_overrun();
    logic [31:0] v;
    millis = 32'd9;
    wr(A_CMP, 32'd10);
    wr(A_PERIOD, 32'd2);
    wr(A_CTRL, 32'h3);
    millis = 32'd10;
    tick();
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL ovr_fire: irq=%b want 1", irq); end
    for (int m = 11; m <= 14; m++) begin
      millis = m;
      tick();
    end
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL ovr_held: irq=%b want 1", irq); end
    ack();
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL ovr_ack: irq=%b want 0", irq); end
    tick();
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL ovr_refire: irq=%b want 1", irq); end
    rd(A_CTRL, v);
    n_tests++;
    if (v !== 32'hF) begin n_fail++; $display("FAIL ovr_ctrl: got %h want f", v); end
    wr(A_CTRL, 32'hB);
    rd(A_CTRL, v);
    n_tests++;
    if (v !== 32'h7) begin n_fail++; $display("FAIL ovr_w1c: got %h want 7", v); end
    wr(A_CTRL, 32'h0);
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL ovr_disable: irq=%b want 0", irq); end
  endtask
`endif

  task automatic test_reset_mid();
    logic [31:0] v;
    millis = 32'd300;
    wr(A_CMP, 32'd250);
    wr(A_PERIOD, 32'd7);
    wr(A_CTRL, 32'h1);
    tick();
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL rstmid_fire: irq=%b want 1", irq); end
    #3 reset = 1'b1;
    #2;
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL rstmid_async: irq=%b want 0", irq); end
    tick();
    #5 reset = 1'b0;
    rd(A_CTRL, v);
    n_tests++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL rstmid_ctrl: got %h want 0", v); end
    rd(A_PERIOD, v);
    n_tests++;
    if (v !== PERIOD_EXP) begin n_fail++; $display("FAIL rstmid_period: got %h want %h", v, PERIOD_EXP); end
    rd(A_CMP, v);
    n_tests++;
    if (v !== 32'd0) begin n_fail++; $display("FAIL rstmid_cmp: got %h want 0", v); end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_past_and_w1c();
    test_wrap();
    test_priority();
`ifdef MILLIS_TIMER_PERIODIC_EN
    test_periodic();
    test_overrun();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
